// File: rtl/svm_pwm_nch.sv
// Center-aligned N-channel space-vector PWM with double-buffered thresholds and a shared multiplier.
// Define DEADTIME_EN to compile in per-channel dead-time insertion on the gate outputs.

module svm_pwm_nch_lane #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                act,
  input  logic                raw,
  input  logic [DT_WIDTH-1:0] dead_time,
  output logic                pwm_hi,
  output logic                pwm_lo
);
`ifdef DEADTIME_EN
  logic                prev_raw, prev_act, dt_edge;
  logic [DT_WIDTH-1:0] dt_cnt;

  // Blanking only on hi<->lo transitions; leaving the inactive state needs none.
  assign dt_edge = act && prev_act && (raw != prev_raw);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_raw <= 1'b0;
      prev_act <= 1'b0;
      dt_cnt   <= '0;
      pwm_hi   <= 1'b0;
      pwm_lo   <= 1'b0;
    end else begin
      prev_raw <= raw;
      prev_act <= act;
      if (!act) begin
        dt_cnt <= '0;
        pwm_hi <= 1'b0;
        pwm_lo <= 1'b0;
      end else if (dt_edge && dead_time != '0) begin
        dt_cnt <= dead_time - DT_WIDTH'(1);
        pwm_hi <= 1'b0;
        pwm_lo <= 1'b0;
      end else if (!dt_edge && dt_cnt != '0) begin
        dt_cnt <= dt_cnt - DT_WIDTH'(1);
        pwm_hi <= 1'b0;
        pwm_lo <= 1'b0;
      end else begin
        dt_cnt <= '0;
        pwm_hi <= raw;
        pwm_lo <= ~raw;
      end
    end
  end
`else
  logic unused_dt;
  assign unused_dt = ^dead_time;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else begin
      pwm_hi <= raw;
      pwm_lo <= act && !raw;
    end
  end
`endif
endmodule

module svm_pwm_nch #(
  parameter int D_WIDTH  = 16,
  parameter int N_CH     = 3,
  parameter int DT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [D_WIDTH-1:0]       period_top,
  input  logic [DT_WIDTH-1:0]      dead_time,
  input  logic [N_CH*D_WIDTH-1:0]  v_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_CH-1:0]          pwm_hi,
  output logic [N_CH-1:0]          pwm_lo,
  output logic                     period_start
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, PEND = 2'd2} state_t;

  logic [D_WIDTH-1:0]             cnt, top_l;
  logic                           dir_up, run, act;
  state_t                         state, state_nx;
  logic [IW-1:0]                  idx;
  logic [N_CH-1:0][D_WIDTH-1:0]   vbuf, pend_t, act_t;
  logic                           active_valid, pending_valid, conv_en, apply, accept;
  logic [D_WIDTH-1:0]             v_sel, t_new;
  logic [D_WIDTH:0]               diff_full;
  logic [2*D_WIDTH-1:0]           prod;
  logic [N_CH-1:0]                raw;
  logic                           unused_bits;

  assign period_start = (cnt == '0);
  assign accept       = in_valid && in_ready;

  // Triangle counter: top and enable are only looked at on the zero cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dir_up <= 1'b1;
      run    <= 1'b0;
      top_l  <= '0;
    end else if (cnt == '0) begin
      top_l  <= period_top;
      dir_up <= 1'b1;
      if (enable && period_top >= D_WIDTH'(2)) begin
        run <= 1'b1;
        cnt <= D_WIDTH'(1);
      end else begin
        run <= 1'b0;
      end
    end else if (dir_up) begin
      if (cnt == top_l) begin
        dir_up <= 1'b0;
        cnt    <= cnt - D_WIDTH'(1);
      end else begin
        cnt <= cnt + D_WIDTH'(1);
      end
    end else begin
      cnt <= cnt - D_WIDTH'(1);
      if (cnt == D_WIDTH'(1)) dir_up <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = CONV;
      CONV:    if (idx == IW'(N_CH - 1)) state_nx = PEND;
      PEND:    if (period_start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state == IDLE);
    conv_en       = (state == CONV);
    pending_valid = (state == PEND);
    apply         = pending_valid && period_start;
  end

  // diff = 0x7FFF..F - v never goes negative or exceeds D_WIDTH bits, so the top bit is dropped.
  assign v_sel       = vbuf[idx];
  assign diff_full   = {2'b00, {(D_WIDTH-1){1'b1}}} - {v_sel[D_WIDTH-1], v_sel};
  assign prod        = {{D_WIDTH{1'b0}}, top_l} * {{D_WIDTH{1'b0}}, diff_full[D_WIDTH-1:0]};
  assign t_new       = prod[2*D_WIDTH-1:D_WIDTH];
  assign unused_bits = diff_full[D_WIDTH] ^ (^prod[D_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      vbuf         <= '0;
      idx          <= '0;
      pend_t       <= '0;
      act_t        <= '0;
      active_valid <= 1'b0;
    end else begin
      if (accept) begin
        vbuf <= v_in;
        idx  <= '0;
      end
      if (conv_en) begin
        pend_t[idx] <= t_new;
        idx         <= idx + IW'(1);
      end
      if (apply) begin
        act_t        <= pend_t;
        active_valid <= 1'b1;
      end
    end
  end

  assign act = active_valid && run;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    assign raw[c] = act && (cnt >= act_t[c]);

    svm_pwm_nch_lane #(.DT_WIDTH(DT_WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .act       (act),
      .raw       (raw[c]),
      .dead_time (dead_time),
      .pwm_hi    (pwm_hi[c]),
      .pwm_lo    (pwm_lo[c])
    );
  end
endmodule

// File: tb/tb_svm_pwm_nch.sv
// Directed bench for svm_pwm_nch: thresholds, double buffering, boundary race, dead time, counter control.
module tb_svm_pwm_nch;
  localparam int DW = 16, NC = 3, DTW = 8;

  logic            clk = 1'b0;
  logic            rst, enable, in_valid;
  logic [DW-1:0]   period_top;
  logic [DTW-1:0]  dead_time;
  logic [NC*DW-1:0] v_in;
  logic            in_ready, period_start;
  logic [NC-1:0]   pwm_hi, pwm_lo;

  int n_cmp = 0, n_fail = 0;
  int hi_cnt[NC], lo_cnt[NC];
  int ovl;

  svm_pwm_nch #(.D_WIDTH(DW), .N_CH(NC), .DT_WIDTH(DTW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period_top(period_top),
    .dead_time(dead_time), .v_in(v_in), .in_valid(in_valid), .in_ready(in_ready),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_pins(input int n);
    for (int c = 0; c < NC; c++) begin hi_cnt[c] = 0; lo_cnt[c] = 0; end
    ovl = 0;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        if (pwm_hi[c] === 1'b1) hi_cnt[c]++;
        if (pwm_lo[c] === 1'b1) lo_cnt[c]++;
        if (pwm_hi[c] === 1'b1 && pwm_lo[c] === 1'b1) ovl++;
      end
    end
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 6000; i++) begin
      if (in_ready === 1'b1) break;
      @(negedge clk);
    end
    if (i == 6000) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: in_ready still %b after 6000 cycles", in_ready);
    end
  endtask

  // Advances at least one cycle, returns the number of cycles until period_start.
  task automatic wait_pstart(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 6000);
    if (n == 6000) begin
      n_cmp++; n_fail++;
      $display("FAIL pstart_timeout: no period_start within 6000 cycles");
    end
  endtask

  task automatic send(input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
    wait_ready();
    v_in = {v2, v1, v0};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    v_in = {NC{16'hDEAD}};
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; period_top = 16'd1000;
    dead_time = '0; v_in = '0;
    tick(3);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    n_cmp++; if (pwm_hi !== 3'b000) begin n_fail++; $display("FAIL reset_hi: got %b expected 000", pwm_hi); end
    n_cmp++; if (pwm_lo !== 3'b000) begin n_fail++; $display("FAIL reset_lo: got %b expected 000", pwm_lo); end
    n_cmp++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL reset_pstart: got %b expected 1", period_start); end
    rst = 1'b0;
  endtask

  task automatic test_conversion();
    int exp_hi[NC] = '{1003, 1503, 2000};
    int exp_lo[NC] = '{997, 497, 0};
    enable = 1'b1;
    tick(5);
    send(16'h0000, 16'h4000, 16'h7FFF);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL accept_drop: in_ready got %b expected 0", in_ready); end
    wait_ready();
    tick(2010);
    count_pins(2000);
    for (int c = 0; c < NC; c++) begin
      n_cmp++; if (hi_cnt[c] !== exp_hi[c]) begin n_fail++; $display("FAIL conv_hi ch%0d: got %0d expected %0d", c, hi_cnt[c], exp_hi[c]); end
      n_cmp++; if (lo_cnt[c] !== exp_lo[c]) begin n_fail++; $display("FAIL conv_lo ch%0d: got %0d expected %0d", c, lo_cnt[c], exp_lo[c]); end
    end
  endtask

  task automatic test_period();
    int n;
    wait_pstart(n);
    wait_pstart(n);
    n_cmp++; if (n !== 2000) begin n_fail++; $display("FAIL period_len: got %0d expected 2000", n); end
  endtask

  task automatic test_neg_fullscale();
    send(16'h8000, 16'h4000, 16'h7FFF);
    wait_ready();
    tick(2010);
    count_pins(2000);
    n_cmp++; if (hi_cnt[0] !== 3) begin n_fail++; $display("FAIL negfs_hi: got %0d expected 3", hi_cnt[0]); end
    n_cmp++; if (lo_cnt[0] !== 1997) begin n_fail++; $display("FAIL negfs_lo: got %0d expected 1997", lo_cnt[0]); end
  endtask

  task automatic test_double_buffer();
    int n, busy, old_hi;
    wait_pstart(n);
    tick(500);
    send(16'h0000, 16'h4000, 16'h7FFF);
    busy = 0; old_hi = 0;
    while (in_ready !== 1'b1 && busy < 5000) begin
      if (pwm_hi[0] === 1'b1) old_hi++;
      busy++;
      @(negedge clk);
    end
    n_cmp++; if (busy !== 1500) begin n_fail++; $display("FAIL dbuf_busy: in_ready low %0d cycles expected 1500", busy); end
    n_cmp++; if (old_hi !== 3) begin n_fail++; $display("FAIL dbuf_old_duty: hi %0d cycles expected 3", old_hi); end
    tick(2010);
    count_pins(2000);
    n_cmp++; if (hi_cnt[0] !== 1003) begin n_fail++; $display("FAIL dbuf_new_duty: got %0d expected 1003", hi_cnt[0]); end
  endtask

  task automatic test_boundary_race();
    int n, busy;
    wait_pstart(n);
    tick(1997);
    send(16'h8000, 16'h4000, 16'h7FFF);
    busy = 0;
    while (in_ready !== 1'b1 && busy < 5000) begin
      busy++;
      @(negedge clk);
    end
    n_cmp++; if (busy !== 2003) begin n_fail++; $display("FAIL race_busy: in_ready low %0d cycles expected 2003", busy); end
    tick(2010);
    count_pins(2000);
    n_cmp++; if (hi_cnt[0] !== 3) begin n_fail++; $display("FAIL race_duty: got %0d expected 3", hi_cnt[0]); end
  endtask

  task automatic test_deadtime();
`ifdef DEADTIME_EN
    int exp_hi[NC] = '{993, 1493, 2000};
    int exp_lo[NC] = '{987, 487, 0};
`else
    int exp_hi[NC] = '{1003, 1503, 2000};
    int exp_lo[NC] = '{997, 497, 0};
`endif
    dead_time = 8'd10;
    send(16'h0000, 16'h4000, 16'h7FFF);
    wait_ready();
    tick(2010);
    count_pins(2000);
    for (int c = 0; c < NC; c++) begin
      n_cmp++; if (hi_cnt[c] !== exp_hi[c]) begin n_fail++; $display("FAIL dt_hi ch%0d: got %0d expected %0d", c, hi_cnt[c], exp_hi[c]); end
      n_cmp++; if (lo_cnt[c] !== exp_lo[c]) begin n_fail++; $display("FAIL dt_lo ch%0d: got %0d expected %0d", c, lo_cnt[c], exp_lo[c]); end
    end
    n_cmp++; if (ovl !== 0) begin n_fail++; $display("FAIL dt_overlap: got %0d expected 0", ovl); end
    dead_time = '0;
  endtask

  task automatic test_top_change();
    int n, g;
    wait_pstart(n);
    g = 0;
    do begin
      @(negedge clk);
      g++;
      if (g == 1) period_top = 16'd500;
    end while (period_start !== 1'b1 && g < 5000);
    n_cmp++; if (g !== 2000) begin n_fail++; $display("FAIL top_mid_period: got %0d expected 2000", g); end
    g = 0;
    do begin
      @(negedge clk);
      g++;
      if (g == 1) period_top = 16'd1000;
    end while (period_start !== 1'b1 && g < 5000);
    n_cmp++; if (g !== 1000) begin n_fail++; $display("FAIL top_new_period: got %0d expected 1000", g); end
    wait_pstart(n);
  endtask

  task automatic test_enable_drop();
    int n, bad;
    wait_pstart(n);
    tick(300);
    enable = 1'b0;
    wait_pstart(n);
    n_cmp++; if (n !== 1700) begin n_fail++; $display("FAIL drop_finish: got %0d expected 1700", n); end
    tick(3);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm_hi !== 3'b000 || pwm_lo !== 3'b000 || period_start !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL drop_stopped: %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid_conv();
    int sum_hi, sum_lo;
    send(16'h0000, 16'h4000, 16'h7FFF);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstconv_ready: got %b expected 1", in_ready); end
    n_cmp++; if ({pwm_hi, pwm_lo} !== 6'b0) begin n_fail++; $display("FAIL rstconv_pins: got %b expected 000000", {pwm_hi, pwm_lo}); end
    rst = 1'b0;
    enable = 1'b1;
    tick(2010);
    count_pins(2000);
    sum_hi = hi_cnt[0] + hi_cnt[1] + hi_cnt[2];
    sum_lo = lo_cnt[0] + lo_cnt[1] + lo_cnt[2];
    n_cmp++; if (sum_hi !== 0 || sum_lo !== 0) begin n_fail++; $display("FAIL rstconv_discard: hi %0d lo %0d expected 0 0", sum_hi, sum_lo); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstconv_idle: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_period();
    test_neg_fullscale();
    test_double_buffer();
    test_boundary_race();
    test_deadtime();
    test_top_change();
    test_enable_drop();
    test_reset_mid_conv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
